// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : RV32I load/store unit. Accepts one memory operation at a time,
//            drives the data-memory req/gnt/rvalid port, and aligns and
//            extends load data onto the register-file write port.
// Ports    : clk_in, rst_in              clock, async active-high reset
//            req_*                       operation from execute stage
//            dmem_*                      data-memory request/response port
//            wb_we/wb_waddr/wb_wdata     register-file write port
//            err_misaligned/err_addr     rejected-operation report
// Config   : define LSU_MISALIGN_TRAP_EN to reject misaligned half/word
//            accesses; otherwise they are forced aligned and proceed.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_we,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_wdata,
  output logic        err_misaligned,
  output logic [31:0] err_addr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_WB   = 2'd3
  } state_e;

  state_e      state_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic        dmem_req_q;
  logic        dmem_we_q;
  logic [3:0]  dmem_be_q;
  logic [31:0] dmem_addr_q;
  logic [31:0] dmem_wdata_q;
  logic        wb_we_q;
  logic [4:0]  wb_waddr_q;
  logic [31:0] wb_wdata_q;
  logic        err_q;
  logic [31:0] err_addr_q;

  // Request decode
  logic        w_f3_ok;
  logic        w_reject;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  always_comb begin
    if (req_we)
      w_f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    else
      w_f3_ok = (req_funct3 != 3'b011) && (req_funct3 != 3'b110) && (req_funct3 != 3'b111);

    // Offset inside the word, forced aligned for half/word accesses.
    case (req_funct3[1:0])
      2'b00: begin
        w_off   = req_addr[1:0];
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_off   = {req_addr[1], 1'b0};
        w_be    = 4'b0011 << w_off;
        w_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        w_off   = 2'b00;
        w_be    = 4'b1111;
        w_wdata = req_wdata;
      end
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_misal;
  assign w_misal  = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign w_reject = !w_f3_ok || w_misal;
`else
  assign w_reject = !w_f3_ok;
`endif

  // Load extraction: low 16 bits of rdata shifted right by the byte offset.
  logic [15:0] w_lo;
  logic [31:0] w_load;

  always_comb begin
    case (off_q)
      2'd0:    w_lo = dmem_rdata[15:0];
      2'd1:    w_lo = dmem_rdata[23:8];
      2'd2:    w_lo = dmem_rdata[31:16];
      default: w_lo = {8'h00, dmem_rdata[31:24]};
    endcase
    case (funct3_q)
      3'b000:  w_load = {{24{w_lo[7]}}, w_lo[7:0]};
      3'b001:  w_load = {{16{w_lo[15]}}, w_lo};
      3'b100:  w_load = {24'h0, w_lo[7:0]};
      3'b101:  w_load = {16'h0, w_lo};
      default: w_load = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      funct3_q     <= 3'b000;
      off_q        <= 2'b00;
      rd_q         <= 5'd0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_be_q    <= 4'b0000;
      dmem_addr_q  <= 32'h0;
      dmem_wdata_q <= 32'h0;
      wb_we_q      <= 1'b0;
      wb_waddr_q   <= 5'd0;
      wb_wdata_q   <= 32'h0;
      err_q        <= 1'b0;
      err_addr_q   <= 32'h0;
    end else begin
      err_q   <= 1'b0;
      wb_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            if (w_reject) begin
              // Rejected: consumed without a memory access.
              err_q      <= 1'b1;
              err_addr_q <= req_addr;
            end else begin
              funct3_q     <= req_funct3;
              off_q        <= w_off;
              rd_q         <= req_rd;
              dmem_req_q   <= 1'b1;
              dmem_we_q    <= req_we;
              dmem_be_q    <= w_be;
              dmem_addr_q  <= {req_addr[31:2], 2'b00};
              dmem_wdata_q <= w_wdata;
              state_q      <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (dmem_gnt) begin
            dmem_req_q <= 1'b0;
            state_q    <= dmem_we_q ? S_IDLE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (dmem_rvalid) begin
            wb_waddr_q <= rd_q;
            wb_wdata_q <= w_load;
            wb_we_q    <= (rd_q != 5'd0);
            state_q    <= S_WB;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready      = (state_q == S_IDLE);
  assign dmem_req       = dmem_req_q;
  assign dmem_we        = dmem_we_q;
  assign dmem_be        = dmem_be_q;
  assign dmem_addr      = dmem_addr_q;
  assign dmem_wdata     = dmem_wdata_q;
  assign wb_we          = wb_we_q;
  assign wb_waddr       = wb_waddr_q;
  assign wb_wdata       = wb_wdata_q;
  assign err_misaligned = err_q;
  assign err_addr       = err_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Self-checking bench for load_store_unit: directed vector table,
//            reset/abort sequences and random operations against a
//            byte-addressed reference memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        err_misaligned;
  logic [31:0] err_addr;

  load_store_unit dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .err_misaligned(err_misaligned), .err_addr(err_addr)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Word memory seen by the DUT, and byte-level reference memory.
  bit [31:0] wmem [bit [31:0]];
  bit [7:0]  bmem [bit [31:0]];

  function automatic bit [31:0] wrd(bit [31:0] a);
    return wmem.exists(a) ? wmem[a] : 32'h0;
  endfunction

  function automatic bit [7:0] brd(bit [31:0] a);
    return bmem.exists(a) ? bmem[a] : 8'h0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  function automatic bit is_legal(bit we, bit [2:0] f3);
    if (we) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  function automatic int nbytes(bit [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  // Runs one full operation from IDLE, checking against the reference model,
  // and reports what the DUT presented.
  task automatic do_op(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                       input bit [31:0] wdata, input bit [4:0] rd,
                       input int gd, input int rvd,
                       output bit [31:0] o_addr, output bit [3:0] o_be,
                       output bit [31:0] o_wdata, output bit [31:0] o_wb,
                       output bit o_err);
    int        n;
    bit        rej;
    bit [31:0] eff, ewd, ewb, wa, w;
    bit [3:0]  ebe;
    n   = nbytes(f3);
    rej = !is_legal(we, f3);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((addr % n) != 0) rej = 1'b1;
`endif
    eff = addr - (addr % n);
    wa  = eff - (eff % 4);
    ebe = 4'b0000;
    for (int i = 0; i < n; i++) ebe[(eff % 4) + i] = 1'b1;
    ewd = (n == 1) ? {4{wdata[7:0]}} : (n == 2) ? {2{wdata[15:0]}} : wdata;
    ewb = 32'h0;
    for (int i = 0; i < n; i++) ewb |= 32'(brd(eff + i)) << (8 * i);
    if (n < 4 && !f3[2] && ewb[8*n-1]) ewb |= ~((32'd1 << (8 * n)) - 1);
    o_addr = 0; o_be = 0; o_wdata = 0; o_wb = 0; o_err = 0;

    chk("ready_idle", req_ready, 1);
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr;
    req_wdata = wdata; req_rd = rd;
    step();
    req_valid = 0; req_addr = $urandom; req_wdata = $urandom;
    o_err = err_misaligned;
    if (rej) begin
      chk("err_pulse", err_misaligned, 1);
      chk("err_addr", err_addr, addr);
      chk("rej_no_req", dmem_req, 0);
      chk("rej_ready", req_ready, 1);
      step();
      chk("err_one_cycle", err_misaligned, 0);
      return;
    end
    chk("no_err", err_misaligned, 0);
    chk("busy", req_ready, 0);
    o_addr = dmem_addr; o_be = dmem_be; o_wdata = dmem_wdata;
    chk("dmem_addr", dmem_addr, wa);
    chk("dmem_be", {28'h0, dmem_be}, {28'h0, ebe});
    chk("dmem_we", dmem_we, we);
    if (we) chk("dmem_wdata", dmem_wdata, ewd);
    for (int i = 0; i < gd; i++) begin
      chk("req_held", dmem_req, 1);
      chk("addr_held", dmem_addr, wa);
      chk("be_held", {28'h0, dmem_be}, {28'h0, ebe});
      step();
    end
    chk("dmem_req", dmem_req, 1);
    dmem_gnt = 1;
    if (we) begin
      w = wrd(wa);
      for (int k = 0; k < 4; k++) if (dmem_be[k]) w[8*k +: 8] = dmem_wdata[8*k +: 8];
      wmem[wa] = w;
      for (int i = 0; i < n; i++) bmem[eff + i] = 8'(wdata >> (8 * i));
    end
    step();
    dmem_gnt = 0;
    chk("req_dropped", dmem_req, 0);
    if (we) begin
      chk("store_ready", req_ready, 1);
      return;
    end
    for (int i = 0; i < rvd; i++) begin
      chk("wait_no_wb", wb_we, 0);
      chk("wait_busy", req_ready, 0);
      step();
    end
    dmem_rvalid = 1; dmem_rdata = wrd(wa);
    step();
    dmem_rvalid = 0; dmem_rdata = $urandom;
    o_wb = wb_wdata;
    chk("wb_we", wb_we, (rd != 0));
    chk("wb_waddr", wb_waddr, rd);
    chk("wb_wdata", wb_wdata, ewb);
    chk("wb_busy", req_ready, 0);
    step();
    chk("wb_we_pulse", wb_we, 0);
    chk("wb_ready", req_ready, 1);
    chk("wb_hold", wb_wdata, ewb);
  endtask

  typedef struct {
    bit        we;
    bit [2:0]  f3;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [4:0]  rd;
    int        gd;
    int        rvd;
    bit        e_err;
    bit [31:0] e_addr;
    bit [3:0]  e_be;
    bit [31:0] e_val;
  } vec_t;

  function automatic vec_t mk(bit we, bit [2:0] f3, bit [31:0] addr, bit [31:0] wdata,
                              bit [4:0] rd, int gd, int rvd, bit e_err,
                              bit [31:0] e_addr, bit [3:0] e_be, bit [31:0] e_val);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd;
    v.gd = gd; v.rvd = rvd; v.e_err = e_err; v.e_addr = e_addr;
    v.e_be = e_be; v.e_val = e_val;
    return v;
  endfunction

  vec_t vecs [15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [31:0] oa, ow, ob;
    bit [3:0]  obe;
    bit        oe;
    bit        we;
    bit [2:0]  f3;
    bit [2:0]  lds [5];
    lds = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    //            we f3    addr        wdata        rd gd rvd err e_addr       e_be     e_val
    vecs[0]  = mk(1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 32'h100, 4'b1111, 32'hDEADBEEF);
    vecs[1]  = mk(0, 3'd2, 32'h100, 32'h0,        5, 0, 0, 0, 32'h100, 4'b1111, 32'hDEADBEEF);
    vecs[2]  = mk(0, 3'd0, 32'h203, 32'h0,        1, 1, 0, 0, 32'h200, 4'b1000, 32'hFFFFFF80);
    vecs[3]  = mk(0, 3'd4, 32'h203, 32'h0,        2, 0, 1, 0, 32'h200, 4'b1000, 32'h00000080);
    vecs[4]  = mk(0, 3'd1, 32'h202, 32'h0,        3, 0, 0, 0, 32'h200, 4'b1100, 32'hFFFF80FF);
    vecs[5]  = mk(0, 3'd5, 32'h200, 32'h0,        4, 2, 2, 0, 32'h200, 4'b0011, 32'h00007F01);
    vecs[6]  = mk(1, 3'd0, 32'h101, 32'h000000AB, 0, 0, 0, 0, 32'h100, 4'b0010, 32'hABABABAB);
    vecs[7]  = mk(0, 3'd2, 32'h100, 32'h0,        6, 0, 0, 0, 32'h100, 4'b1111, 32'hDEADABEF);
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[8]  = mk(0, 3'd2, 32'h102, 32'h0,        7, 0, 0, 1, 32'h0,   4'b0000, 32'h0);
    vecs[12] = mk(0, 3'd1, 32'h201, 32'h0,        8, 0, 0, 1, 32'h0,   4'b0000, 32'h0);
`else
    vecs[8]  = mk(0, 3'd2, 32'h102, 32'h0,        7, 0, 0, 0, 32'h100, 4'b1111, 32'hDEADABEF);
    vecs[12] = mk(0, 3'd1, 32'h201, 32'h0,        8, 0, 0, 0, 32'h200, 4'b0011, 32'h00007F01);
`endif
    vecs[9]  = mk(0, 3'd3, 32'h300, 32'h0,        8, 0, 0, 1, 32'h0,   4'b0000, 32'h0);
    vecs[10] = mk(1, 3'd4, 32'h304, 32'h55,       0, 0, 0, 1, 32'h0,   4'b0000, 32'h0);
    vecs[11] = mk(0, 3'd2, 32'h100, 32'h0,        0, 3, 4, 0, 32'h100, 4'b1111, 32'hDEADABEF);
    vecs[13] = mk(1, 3'd1, 32'h302, 32'h00001234, 0, 0, 0, 0, 32'h300, 4'b1100, 32'h12341234);
    vecs[14] = mk(0, 3'd1, 32'h302, 32'h0,        9, 0, 0, 0, 32'h300, 4'b1100, 32'h00001234);

    wmem[32'h200] = 32'h80FF7F01;
    bmem[32'h200] = 8'h01; bmem[32'h201] = 8'h7F;
    bmem[32'h202] = 8'hFF; bmem[32'h203] = 8'h80;

    rst_in = 1; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0;
    req_wdata = 0; req_rd = 0; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    step(); step();
    chk("rst_ready", req_ready, 1);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_dmem_be", {28'h0, dmem_be}, 32'h0);
    chk("rst_dmem_addr", dmem_addr, 0);
    chk("rst_dmem_wdata", dmem_wdata, 0);
    chk("rst_wb_we", wb_we, 0);
    chk("rst_wb_waddr", wb_waddr, 0);
    chk("rst_wb_wdata", wb_wdata, 0);
    chk("rst_err", err_misaligned, 0);
    chk("rst_err_addr", err_addr, 0);
    rst_in = 0;
    step();

    // Stray handshakes while idle are ignored.
    dmem_gnt = 1; dmem_rvalid = 1; step();
    dmem_gnt = 0; dmem_rvalid = 0;
    chk("stray_req", dmem_req, 0);
    chk("stray_wb", wb_we, 0);
    chk("stray_ready", req_ready, 1);

    for (int i = 0; i < 15; i++) begin
      do_op(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].rd,
            vecs[i].gd, vecs[i].rvd, oa, obe, ow, ob, oe);
      chk($sformatf("vec%0d_err", i), oe, vecs[i].e_err);
      if (!vecs[i].e_err) begin
        chk($sformatf("vec%0d_addr", i), oa, vecs[i].e_addr);
        chk($sformatf("vec%0d_be", i), {28'h0, obe}, {28'h0, vecs[i].e_be});
        if (vecs[i].we) chk($sformatf("vec%0d_wdata", i), ow, vecs[i].e_val);
        else            chk($sformatf("vec%0d_wb", i), ob, vecs[i].e_val);
      end
    end

    // Reset during REQ drops dmem_req without waiting for a clock edge.
    req_valid = 1; req_we = 0; req_funct3 = 3'd2; req_addr = 32'h200; req_rd = 5'd9;
    step();
    req_valid = 0;
    chk("abort_req_hi", dmem_req, 1);
    #2 rst_in = 1;
    #1;
    chk("abort_req_async", dmem_req, 0);
    chk("abort_ready_async", req_ready, 1);
    step();
    rst_in = 0;

    // Reset during WAIT, then a late rvalid must not write back.
    req_valid = 1; req_we = 0; req_funct3 = 3'd2; req_addr = 32'h100; req_rd = 5'd10;
    step();
    req_valid = 0; dmem_gnt = 1;
    step();
    dmem_gnt = 0;
    chk("wait_state", req_ready, 0);
    #2 rst_in = 1;
    step();
    rst_in = 0;
    step();
    chk("ready_after_rst", req_ready, 1);
    dmem_rvalid = 1; dmem_rdata = 32'h12345678;
    step();
    dmem_rvalid = 0;
    chk("late_rvalid_wb_we", wb_we, 0);
    chk("late_rvalid_wdata", wb_wdata, 0);
    chk("late_rvalid_ready", req_ready, 1);
    step();
    chk("late_rvalid_wb_we2", wb_we, 0);

    // Random operations in a small region against the reference model.
    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) f3 = 3'($urandom_range(0, 7));
      else if (we)                   f3 = 3'($urandom_range(0, 2));
      else                           f3 = lds[$urandom_range(0, 4)];
      do_op(we, f3, 32'h400 + $urandom_range(0, 63), $urandom, 5'($urandom_range(0, 31)),
            $urandom_range(0, 3), $urandom_range(0, 3), oa, obe, ow, ob, oe);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
